// File: rtl/stim_sequencer_if.sv
// Host-side bus of the stimulus sequencer: table load port, playback
// control and the replayed output/status signals.
interface stim_sequencer_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 32,
  parameter int unsigned PS_WIDTH = 16,
  parameter int unsigned AW       = $clog2(DEPTH)
);
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [TS_WIDTH-1:0] wr_time;
  logic [WIDTH-1:0]    wr_value;
  logic [AW:0]         num_events;
  logic [PS_WIDTH-1:0] prescale;
  logic                loop;
  logic                start;
  logic                abort;
  logic [WIDTH-1:0]    out;
  logic                busy;
  logic                done;
  logic                event_strobe;
  logic [AW-1:0]       event_idx;

  modport master (
    output wr_en, wr_addr, wr_time, wr_value,
    output num_events, prescale, loop, start, abort,
    input  out, busy, done, event_strobe, event_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_time, wr_value,
    input  num_events, prescale, loop, start, abort,
    output out, busy, done, event_strobe, event_idx
  );
endinterface

// File: rtl/stim_sequencer.sv
// Replays a host-loaded (timestamp, value) table onto a parallel output bus,
// timestamps counted in prescaled ticks from start; one-shot or looped.
module stim_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 32,
  parameter int unsigned PS_WIDTH = 16,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  stim_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [TS_WIDTH-1:0] r_tab_time [DEPTH];
  logic [WIDTH-1:0]    r_tab_val  [DEPTH];

  logic [AW:0]         r_num;
  logic [PS_WIDTH-1:0] r_prescale;
  logic                r_loop;
  logic [PS_WIDTH-1:0] r_ps_cnt;
  logic [TS_WIDTH-1:0] r_time_cnt;
  logic [AW-1:0]       r_idx;

  logic [WIDTH-1:0]    r_out;
  logic                r_strobe;
  logic [AW-1:0]       r_event_idx;

  logic [AW:0]         w_num_clamp;
  logic                w_tick;
  logic                w_fire;
  logic                w_last;
  logic                w_busy;
  logic                w_done;

  assign w_num_clamp = (bus.num_events > L_DEPTH) ? L_DEPTH : bus.num_events;
  assign w_tick      = (r_ps_cnt == r_prescale);
  assign w_fire      = (r_state == S_RUN) && (r_time_cnt >= r_tab_time[r_idx]);
  assign w_last      = ({1'b0, r_idx} == (r_num - (AW+1)'(1)));

  // Table has no reset; the write port is closed only while playing.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !w_busy) begin
      r_tab_time[bus.wr_addr] <= bus.wr_time;
      r_tab_val[bus.wr_addr]  <= bus.wr_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            w_state_nxt = (w_num_clamp == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_fire && w_last && !r_loop) begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num       <= '0;
      r_prescale  <= '0;
      r_loop      <= 1'b0;
      r_ps_cnt    <= '0;
      r_time_cnt  <= '0;
      r_idx       <= '0;
      r_out       <= '0;
      r_strobe    <= 1'b0;
      r_event_idx <= '0;
    end else begin
      r_strobe <= 1'b0;
      if (!bus.abort) begin
        if (r_state != S_RUN) begin
          if (bus.start) begin
            r_num      <= w_num_clamp;
            r_prescale <= bus.prescale;
            r_loop     <= bus.loop;
            r_ps_cnt   <= '0;
            r_time_cnt <= '0;
            r_idx      <= '0;
          end
        end else begin
          if (w_tick) begin
            r_ps_cnt <= '0;
            if (!(&r_time_cnt)) begin
              r_time_cnt <= r_time_cnt + TS_WIDTH'(1);
            end
          end else begin
            r_ps_cnt <= r_ps_cnt + PS_WIDTH'(1);
          end
          // Loop wrap is written last so it overrides a coincident tick.
          if (w_fire) begin
            r_out       <= r_tab_val[r_idx];
            r_strobe    <= 1'b1;
            r_event_idx <= r_idx;
            if (w_last) begin
              if (r_loop) begin
                r_idx      <= '0;
                r_time_cnt <= '0;
                r_ps_cnt   <= '0;
              end
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
      end
    end
  end

  assign bus.out          = r_out;
  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.event_strobe = r_strobe;
  assign bus.event_idx    = r_event_idx;

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
Synthesizable multi-channel stimulus sequencer that replays a host-loaded table of (timestamp, value) events onto a parallel output bus. Timestamps are measured against a prescaled timebase. It supports one-shot or looped playback with start/abort control. It drives bench or on-board bitbang outputs for logic-analyser capture, and replaces file-driven playback wherever simulation-only file I/O is unavailable.

Parameters:
WIDTH, 8, number of output channels (bits of out / wr_value)
DEPTH, 16, event table entries (power of two, >=2)
TS_WIDTH, 32, timestamp and time-counter width
PS_WIDTH, 16, prescaler width
AW, $clog2(DEPTH), table address width (derived)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  table write strobe; honoured only when busy=0
wr_addr  input  AW  table entry index
wr_time  input  TS_WIDTH  entry timestamp, in ticks from start
wr_value  input  WIDTH  entry output value
num_events  input  AW+1  entries to play, sampled on start; values >DEPTH clamp to DEPTH
prescale  input  PS_WIDTH  tick period minus one, sampled on start
loop  input  1  restart from entry 0 after last entry; sampled on start
start  input  1  begin playback (level, sampled each clock in IDLE/DONE)
abort  input  1  stop playback and return to IDLE
out  output  WIDTH  registered stimulus output
busy  output  1  high in RUN
done  output  1  high in DONE
event_strobe  output  1  one-cycle pulse on the edge an event is applied
event_idx  output  AW  index of the entry applied with the current strobe

Behaviour:
- Reset (rst_n low, async): state=IDLE, out=0, busy=0, done=0, event_strobe=0, event_idx=0, time/prescale counters=0. Table contents are not reset.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- IDLE/DONE + start=1 at edge k:
  - Latch num_events (clamped), prescale and loop.
  - Set time_cnt=0, ps_cnt=0, idx=0.
  - Go to RUN, or to DONE if latched num_events=0 (no strobes are issued).
- Priority: abort over start. abort=1 in any state at an edge moves to IDLE. out holds its value and no strobe is issued.
- Tick: ps_cnt counts 0..prescale and wraps; tick is asserted on the wrap. prescale=0 gives a tick every clock.
- time_cnt increments on each tick while in RUN and saturates at all-ones (no wrap).
- Event fire: in RUN, if time_cnt >= table[idx].time at an edge:
  - out<=table[idx].value, event_strobe<=1, event_idx<=idx.
  - At most one event fires per clock. Equal or non-increasing timestamps fire on consecutive clocks.
- Timing: event at time T with no backlog fires at edge k+1+T*(prescale+1). out is visible after that edge.
- Last entry (idx==num_events-1) fired:
  - loop=0: go to DONE.
  - loop=1: idx<=0, time_cnt<=0, ps_cnt<=0. The wrap reset takes priority over a coincident tick.
- Otherwise idx<=idx+1. A tick coincident with a fire still advances time_cnt.
- Table writes while busy=1 are ignored. A write and a start in the same cycle: the write lands and start proceeds, so the new entry is visible to playback.
- Table read is combinational from registers (or synchronous RAM with a one-entry lookahead). Either way, the fire timing above is mandatory.
- DONE: out holds, done stays high until start (restart) or abort (to IDLE).
- start while in RUN is ignored.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> out=0, busy=0, done=0, event_strobe=0 immediately, with no clock needed.
- One-shot, prescale=0, entries {(0,0x01),(3,0x02),(5,0x00)}, start at edge k -> out=0x01 @k+1, 0x02 @k+4, 0x00 @k+6; strobes with idx 0,1,2; done=1 after k+6.
- Prescale=3, entries {(2,0xAA)} -> out=0xAA at edge k+9; busy high from k+1 to k+9.
- Backlog: entries {(0,1),(0,2),(0,3)} -> out 1,2,3 on edges k+1,k+2,k+3, one strobe each.
- Loop=1, entries {(0,0x0F),(1,0xF0)} -> out alternates 0x0F/0xF0 with period 2 clocks indefinitely; abort -> IDLE, out frozen at last value.
- Writes: wr_en during RUN to idx 1 -> playback unaffected. start with num_events=0 -> DONE next edge, no strobe. num_events=31 with DEPTH=16 -> exactly 16 strobes.
